// File: rtl/h_decoder_11_7.sv
// SEC-DED (11,7) Hamming decoder with overall parity and one output register stage.
// Ports: i_Clk, i_Rst (async high), i_CodeWord[11:0] in; o_Syndrome[4:0], o_DecodWord[6:0], o_ErrorC, o_ErrorD out.
module h_decoder_11_7 (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [11:0] i_CodeWord,
    output logic [4:0]  o_Syndrome,
    output logic [6:0]  o_DecodWord,
    output logic        o_ErrorC,
    output logic        o_ErrorD
);

    logic [3:0]  syn_s;
    logic        syn_p;
    logic [11:0] fix_mask;
    logic [11:0] cw_fixed;

    logic [4:0]  syndrome_d, syndrome_q;
    logic [6:0]  decod_word_d, decod_word_q;
    logic        error_c_d, error_c_q;
    logic        error_d_d, error_d_q;

    // Each syndrome bit covers the positions whose index has that bit set.
    always_comb begin
        syn_s[0] = ^{i_CodeWord[1], i_CodeWord[3], i_CodeWord[5],
                     i_CodeWord[7], i_CodeWord[9], i_CodeWord[11]};
        syn_s[1] = ^{i_CodeWord[2], i_CodeWord[3], i_CodeWord[6],
                     i_CodeWord[7], i_CodeWord[10], i_CodeWord[11]};
        syn_s[2] = ^{i_CodeWord[4], i_CodeWord[5],
                     i_CodeWord[6], i_CodeWord[7]};
        syn_s[3] = ^{i_CodeWord[8], i_CodeWord[9],
                     i_CodeWord[10], i_CodeWord[11]};
        syn_p    = ^i_CodeWord;
    end

    always_comb begin
        fix_mask  = '0;
        error_c_d = 1'b0;
        error_d_d = 1'b0;
        if (syn_p) begin
            if (syn_s == 4'd0) begin
                // Only the overall parity bit flipped; data is intact.
                error_c_d = 1'b1;
            end else if (syn_s <= 4'd11) begin
                fix_mask  = 12'b1 << syn_s;
                error_c_d = 1'b1;
            end else begin
                // Syndrome points past the codeword: multi-bit error.
                error_d_d = 1'b1;
            end
        end else if (syn_s != 4'd0) begin
            error_d_d = 1'b1;
        end
    end

    always_comb begin
        cw_fixed     = i_CodeWord ^ fix_mask;
        decod_word_d = {cw_fixed[11], cw_fixed[10], cw_fixed[9], cw_fixed[7],
                        cw_fixed[6], cw_fixed[5], cw_fixed[3]};
        syndrome_d   = {syn_p, syn_s};
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            syndrome_q   <= '0;
            decod_word_q <= '0;
            error_c_q    <= 1'b0;
            error_d_q    <= 1'b0;
        end else begin
            syndrome_q   <= syndrome_d;
            decod_word_q <= decod_word_d;
            error_c_q    <= error_c_d;
            error_d_q    <= error_d_d;
        end
    end

    assign o_Syndrome  = syndrome_q;
    assign o_DecodWord = decod_word_q;
    assign o_ErrorC    = error_c_q;
    assign o_ErrorD    = error_d_q;

endmodule

// File: tb/tb_h_decoder_11_7.sv
// Testbench for h_decoder_11_7: reference model plus per-cycle compare and literal vectors.
// Drives directed codewords, mid-stream async reset, and checks every output cycle.
module tb_h_decoder_11_7;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic [11:0] i_CodeWord = '0;
    logic [4:0]  o_Syndrome;
    logic [6:0]  o_DecodWord;
    logic        o_ErrorC;
    logic        o_ErrorD;

    int errors = 0;
    int checks = 0;

    h_decoder_11_7 dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_CodeWord (i_CodeWord),
        .o_Syndrome (o_Syndrome),
        .o_DecodWord(o_DecodWord),
        .o_ErrorC   (o_ErrorC),
        .o_ErrorD   (o_ErrorD)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference: syndrome is the XOR of the indices of all set positions.
    function automatic logic [13:0] model(input logic [11:0] cw);
        logic [3:0]  s;
        logic        p;
        logic [11:0] c;
        logic [6:0]  dw;
        logic        ec;
        logic        ed;
        int          pos[7] = '{3, 5, 6, 7, 9, 10, 11};
        s  = 4'd0;
        for (int k = 1; k <= 11; k++)
            if (cw[k]) s = s ^ 4'(k);
        p  = ^cw;
        c  = cw;
        ec = 1'b0;
        ed = 1'b0;
        if (p) begin
            if (s == 4'd0) ec = 1'b1;
            else if (s <= 4'd11) begin
                c[s] = ~c[s];
                ec   = 1'b1;
            end else ed = 1'b1;
        end else if (s != 4'd0) ed = 1'b1;
        for (int d = 0; d < 7; d++)
            dw[d] = c[pos[d]];
        return {p, s, dw, ec, ed};
    endfunction

    logic [13:0] exp_q = '0;

    always @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) exp_q = '0;
        else       exp_q = model(i_CodeWord);
    end

    always @(negedge i_Clk) begin
        checks++;
        if ({o_Syndrome, o_DecodWord, o_ErrorC, o_ErrorD} !== exp_q) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got sy=%b dw=%h ec=%b ed=%b need sy=%b dw=%h ec=%b ed=%b",
                     $time, o_Syndrome, o_DecodWord, o_ErrorC, o_ErrorD,
                     exp_q[13:9], exp_q[8:2], exp_q[1], exp_q[0]);
        end
        checks++;
        if (o_ErrorC && o_ErrorD) begin
            errors++;
            $display("FAIL ec_ed_excl t=%0t got ec=1 ed=1 need not both", $time);
        end
    end

    task automatic check_lit(input string name, input logic [11:0] cw,
                             input logic [4:0] sy, input logic [6:0] dw,
                             input logic ec, input logic ed);
        logic [13:0] m;
        m = model(cw);
        checks++;
        if ({o_Syndrome, o_DecodWord, o_ErrorC, o_ErrorD} !== {sy, dw, ec, ed}) begin
            errors++;
            $display("FAIL %s dut got sy=%b dw=%h ec=%b ed=%b need sy=%b dw=%h ec=%b ed=%b",
                     name, o_Syndrome, o_DecodWord, o_ErrorC, o_ErrorD, sy, dw, ec, ed);
        end
        checks++;
        if (m !== {sy, dw, ec, ed}) begin
            errors++;
            $display("FAIL %s model got %b need %b", name, m, {sy, dw, ec, ed});
        end
    endtask

    task automatic step(input logic [11:0] cw);
        i_CodeWord = cw;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        #2;
        check_lit("reset_hold", 12'h000, 5'b00000, 7'h00, 1'b0, 1'b0);
        @(negedge i_Clk);
        #1;
        check_lit("reset_hold2", 12'h000, 5'b00000, 7'h00, 1'b0, 1'b0);
        i_CodeWord = 12'h5A5;
        #1;
        i_Rst = 1'b0;

        step(12'h000);
        check_lit("zero", 12'h000, 5'b00000, 7'h00, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [11:0] cw;
            logic [4:0]  sy;
            cw = 12'(1) << i;
            sy = (i == 0) ? 5'b10000 : {1'b1, 4'(i)};
            step(cw);
            check_lit($sformatf("sweep_%0d", i), cw, sy, 7'h00, 1'b1, 1'b0);
            step(12'h000);
        end

        step(12'hFFF);
        check_lit("all_ones", 12'hFFF, 5'b00000, 7'h7F, 1'b0, 1'b0);
        step(12'hFDF);
        check_lit("pos5_flip", 12'hFDF, 5'b10101, 7'h7F, 1'b1, 1'b0);
        step(12'h006);
        check_lit("double", 12'h006, 5'b00011, 7'h00, 1'b0, 1'b1);
        step(12'h111);
        check_lit("invalid_pos", 12'h111, 5'b11100, 7'h00, 1'b0, 1'b1);

        // Back-to-back mixed words; covered by the per-cycle compare.
        step(12'hA5C);
        step(12'h3C7);
        step(12'h7E1);
        step(12'h818);
        step(12'hFFE);

        step(12'hFDF);
        #2;
        i_Rst = 1'b1;
        #1;
        check_lit("async_rst", 12'h000, 5'b00000, 7'h00, 1'b0, 1'b0);
        i_CodeWord = 12'h006;
        @(negedge i_Clk);
        #1;
        i_CodeWord = 12'hFFF;
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
        check_lit("post_rst", 12'hFFF, 5'b00000, 7'h7F, 1'b0, 1'b0);

        step(12'h111);
        step(12'h000);
        @(negedge i_Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
